// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples the carry through one CHUNK-bit slice per clock.
// Valid/ready on both sides; accepts only in IDLE and holds the result in DONE until it is taken.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [31:0]       base;
  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_c;
  logic [WIDTH-1:0]  sum_next;
  logic              last;

  always_comb begin
    base     = 32'(idx) * 32'(CHUNK);
    slice_a  = a_q[base +: CHUNK];
    slice_b  = b_q[base +: CHUNK];
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
    sum_next = sum;
    sum_next[base +: CHUNK] = slice_s;
    last     = (idx == IDXW'(NCHUNK - 1));
  end

  // b_q already holds the effective (possibly inverted) operand, so the carry into
  // the MSB is recovered as a^b^s at that bit for the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sum   <= sum_next;
          carry <= slice_c;
          idx   <= idx + 1'b1;
          if (last) begin
            cout      <= slice_c;
            overflow  <= slice_c ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[CHUNK-1]);
            zero      <= (sum_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and random checks of chunked_adder at (32,8), (12,4) and (1,1) against hand values and a model.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_d;
  logic [31:0] a_d, b_d;
  logic        cin_d, sub_d, out_ready_d;
  int          sel;

  logic [2:0]  iv, ir, ov, co, of, zr;
  logic [31:0] s0;
  logic [11:0] s1;
  logic [0:0]  s2;

  logic        obs_ready, obs_valid, obs_cout, obs_ovf, obs_zero;
  logic [31:0] obs_sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign iv[0] = in_valid_d && (sel == 0);
  assign iv[1] = in_valid_d && (sel == 1);
  assign iv[2] = in_valid_d && (sel == 2);

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(ov[0]), .out_ready(out_ready_d),
    .sum(s0), .cout(co[0]), .overflow(of[0]), .zero(zr[0]));

  chunked_adder #(.WIDTH(12), .CHUNK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_d[11:0]), .b(b_d[11:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(ov[1]), .out_ready(out_ready_d),
    .sum(s1), .cout(co[1]), .overflow(of[1]), .zero(zr[1]));

  chunked_adder #(.WIDTH(1), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_d[0:0]), .b(b_d[0:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(ov[2]), .out_ready(out_ready_d),
    .sum(s2), .cout(co[2]), .overflow(of[2]), .zero(zr[2]));

  always_comb begin
    obs_ready = ir[0];
    obs_valid = ov[0];
    obs_cout  = co[0];
    obs_ovf   = of[0];
    obs_zero  = zr[0];
    obs_sum   = s0;
    case (sel)
      1: begin
        obs_ready = ir[1]; obs_valid = ov[1]; obs_cout = co[1];
        obs_ovf = of[1]; obs_zero = zr[1]; obs_sum = {20'd0, s1};
      end
      2: begin
        obs_ready = ir[2]; obs_valid = ov[2]; obs_cout = co[2];
        obs_ovf = of[2]; obs_zero = zr[2]; obs_sum = {31'd0, s2};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int s);
    case (s)
      0: return 32;
      1: return 12;
      default: return 1;
    endcase
  endfunction

  function automatic int lat_of(input int s);
    case (s)
      0: return 5;
      1: return 4;
      default: return 2;
    endcase
  endfunction

  // Full-width reference: a + b_eff + c0 with the carry taken from bit w.
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb, output logic [31:0] es,
                       output logic ec, output logic eo, output logic ez);
    logic [63:0] mask, am, bm, full;
    logic        c0;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, av} & mask;
    bm   = sb ? (~{32'd0, bv}) & mask : {32'd0, bv} & mask;
    c0   = sb ? ~ci : ci;
    full = am + bm + {63'd0, c0};
    es   = 32'(full & mask);
    ec   = full[w];
    eo   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    ez   = ((full & mask) == 64'd0);
  endtask

  task automatic do_op(input string tag, input int s, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez);
    int n;
    sel = s;
    out_ready_d = 1'b1;
    @(posedge clk); #1;
    check({tag, "_in_ready"}, 64'(obs_ready), 64'd1);
    a_d = av; b_d = bv; cin_d = ci; sub_d = sb; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    n = 1;
    while (!obs_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat_of(s)));
    check({tag, "_sum"}, 64'(obs_sum), 64'(es));
    check({tag, "_cout"}, 64'(obs_cout), 64'(ec));
    check({tag, "_ovf"}, 64'(obs_ovf), 64'(eo));
    check({tag, "_zero"}, 64'(obs_zero), 64'(ez));
    @(posedge clk); #1;
    check({tag, "_hs_valid"}, 64'(obs_valid), 64'd0);
    check({tag, "_hs_ready"}, 64'(obs_ready), 64'd1);
  endtask

  task automatic rand_op(input int s, input logic sb);
    logic [31:0] av, bv, es;
    logic        ci, ec, eo, ez;
    av = $urandom;
    bv = $urandom;
    ci = 1'($urandom_range(0, 1));
    model(width_of(s), av, bv, ci, sb, es, ec, eo, ez);
    do_op(sb ? "rand_sub" : "rand_add", s, av, bv, ci, sb, es, ec, eo, ez);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(obs_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(obs_valid), 64'd0);
    check({tag, "_sum"}, 64'(obs_sum), 64'd0);
    check({tag, "_cout"}, 64'(obs_cout), 64'd0);
    check({tag, "_ovf"}, 64'(obs_ovf), 64'd0);
    check({tag, "_zero"}, 64'(obs_zero), 64'd0);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (obs_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid_d = 1'b0; a_d = '0; b_d = '0;
    cin_d = 1'b0; sub_d = 1'b0; out_ready_d = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    #2 rst_n = 1'b1;
    watch_no_valid("rst_no_spurious", 4);

    // Park a nonzero result in DONE, then drop reset mid-cycle.
    out_ready_d = 1'b0;
    a_d = 32'h0000_0012; b_d = 32'h0000_0034; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_arst_valid", 64'(obs_valid), 64'd1);
    check("pre_arst_sum", 64'(obs_sum), 64'h46);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("arst_done");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_d = 1'b1;
    watch_no_valid("arst_no_spurious", 8);

    do_op("carry_wrap", 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_op("pos_ovf",    0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op("neg_ovf",    0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    do_op("sub_5_7",    0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_7_5_b",  0, 32'd7, 32'd5, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    do_op("all_ones_c", 0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_op("w12_wrap",   1, 32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure: inputs churn during BUSY/DONE, out_ready low for 6 DONE cycles.
    sel = 0;
    out_ready_d = 1'b0;
    @(posedge clk); #1;
    a_d = 32'h1111_1111; b_d = 32'h2222_2222; cin_d = 1'b1; sub_d = 1'b0; in_valid_d = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40 && !obs_valid; i++) begin
      check("bp_busy_in_ready", 64'(obs_ready), 64'd0);
      a_d = $urandom; b_d = $urandom; sub_d = 1'b1; in_valid_d = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      check("bp_done_valid", 64'(obs_valid), 64'd1);
      check("bp_done_in_ready", 64'(obs_ready), 64'd0);
      check("bp_done_sum", 64'(obs_sum), 64'h3333_3334);
      check("bp_done_flags", 64'({obs_cout, obs_ovf, obs_zero}), 64'd0);
      @(posedge clk); #1;
    end
    in_valid_d = 1'b0;
    out_ready_d = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(obs_valid), 64'd0);
    check("bp_release_in_ready", 64'(obs_ready), 64'd1);

    // Reset pulse during BUSY discards the in-flight result.
    a_d = 32'h0000_00AA; b_d = 32'h0000_0055; cin_d = 1'b0; sub_d = 1'b0; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    watch_no_valid("busy_rst_no_result", 10);
    do_op("after_rst_3p4", 0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

    // 1-bit full-adder truth table.
    for (int k = 0; k < 8; k++) begin
      logic [31:0] av, bv, es;
      logic        ci, ec, eo, ez;
      av = 32'((k >> 2) & 1);
      bv = 32'((k >> 1) & 1);
      ci = 1'(k & 1);
      es = 32'((k & 1) ^ ((k >> 1) & 1) ^ ((k >> 2) & 1));
      ec = ((k & 3) == 3) || ((k & 5) == 5) || ((k & 6) == 6);
      eo = (av[0] == bv[0]) && (es[0] != av[0]);
      ez = (es == 0);
      do_op("fa1", 2, av, bv, ci, 1'b0, es, ec, eo, ez);
    end

    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 1000; i++) rand_op(s, 1'(m));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
